exu_disp: RTL and testbench
===========================

EXU_DISP -- requirements
Module: exu_disp

Interface
REQ-001 SHALL have parameter NUM_FU, default 4, number of functional-unit channels (1..16).
REQ-002 SHALL have parameter XLEN, default 32, datapath width.
REQ-003 SHALL have parameter TMO_W, default 8, watchdog counter width.
REQ-004 SHALL have port clk  in  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_val  in  1  upstream instruction valid.
REQ-007 SHALL have port o_rdy  out  1  upstream ready; accept = i_val & o_rdy.
REQ-008 SHALL have port i_sele  in  NUM_FU  one-hot functional-unit select.
REQ-009 SHALL have port i_pc  in  XLEN  instruction PC, carried to writeback.
REQ-010 SHALL have port o_fu_val  out  NUM_FU  per-FU request valid.
REQ-011 SHALL have port i_fu_rdy  in  NUM_FU  per-FU completion.
REQ-012 SHALL have port i_fu_res  in  NUM_FU*XLEN  per-FU result; FU k occupies bits [k*XLEN +: XLEN].
REQ-013 SHALL have port o_wb_val  out  1  writeback valid.
REQ-014 SHALL have port i_wb_rdy  in  1  writeback ready.
REQ-015 SHALL have port o_wb_res  out  XLEN  registered result.
REQ-016 SHALL have port o_wb_pc  out  XLEN  PC of the result.
REQ-017 SHALL have port o_wb_ilg  out  1  illegal select flag.
REQ-018 SHALL have port o_wb_tmo  out  1  watchdog timeout flag.
REQ-019 SHALL have port o_retire_cnt  out  32  count of legal, non-timed-out completions.

Function
REQ-020 SHALL implement an FSM with states IDLE, BUSY and WB.
REQ-021 In IDLE, o_rdy SHALL be 1; on accept, i_sele and i_pc SHALL be latched and the FSM SHALL go to BUSY.
REQ-022 If the latched select is zero or multi-hot, the FSM SHALL go to WB with o_wb_ilg=1 and o_wb_res=0, with no o_fu_val asserted.
REQ-023 In BUSY, o_fu_val SHALL equal the latched one-hot select, and all other bits SHALL be 0.
REQ-024 In BUSY, when i_fu_rdy of the selected FU is 1: capture its result, then go to WB. Non-selected i_fu_rdy bits SHALL be ignored.
REQ-025 Minimum latency: accept at cycle N, o_fu_val at N+1, o_wb_val at N+2 when the FU is ready at N+1.
REQ-026 In WB, o_wb_val SHALL be 1 and o_wb_res/pc/ilg/tmo SHALL hold stable until i_wb_rdy.
REQ-027 In WB, o_rdy SHALL equal i_wb_rdy; a simultaneous accept SHALL go directly to BUSY (or to WB for an illegal select), giving back-to-back issue with no bubble.
REQ-028 On a WB handshake with no new accept, the FSM SHALL go to IDLE.
REQ-029 o_retire_cnt SHALL increment by 1 on each WB handshake with ilg=0 and tmo=0, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-030 In BUSY and IDLE, o_rdy SHALL be 0 in BUSY and o_wb_val SHALL be 0 in both.

Reset
REQ-031 When rst=1 at a clock edge: FSM to IDLE; o_fu_val=0; o_wb_val=0; o_wb_res/o_wb_pc=0; o_wb_ilg/o_wb_tmo=0; o_retire_cnt=0; watchdog=0.
REQ-032 Reset asserted in BUSY or WB SHALL abandon the in-flight operation without a retire count.

Configuration
REQ-033 Macro CIRNO_EXU_TMO_EN SHALL gate the watchdog.
REQ-034 With CIRNO_EXU_TMO_EN defined: a TMO_W-bit counter clears on entry to BUSY and increments each BUSY cycle. When it reaches 2^TMO_W-1 without FU ready: drop o_fu_val, go to WB with o_wb_tmo=1 and o_wb_res=0. If FU ready arrives in the same cycle, ready SHALL win.
REQ-035 Without CIRNO_EXU_TMO_EN: BUSY SHALL wait indefinitely, o_wb_tmo SHALL be constant 0, and no counter SHALL be instantiated.

Structure
REQ-036 FSM state encodings and the CIRNO_EXU_TMO_EN default SHALL live in the shared cirno9_define file.
REQ-037 One combinational sub-module, exu_fu_mux, SHALL do the one-hot legality check and the AND-OR result select across NUM_FU channels.

Verification
REQ-038 NUM_FU=4, i_sele=4'b0010, FU1 ready one cycle after o_fu_val with res=0x1234 -> o_wb_val at N+2, o_wb_res=0x1234, retire_cnt=1.
REQ-039 i_sele=4'b0110 -> o_fu_val stays 0, WB with o_wb_ilg=1 and res=0, retire_cnt unchanged.
REQ-040 i_wb_rdy held 0 for 5 cycles -> o_wb_* stable and o_rdy=0 throughout; i_wb_rdy=1 with i_val=1 -> next cycle BUSY with the new select.
REQ-041 TMO_EN defined, TMO_W=4, FU never ready -> o_wb_tmo=1 after 15 BUSY cycles; with macro undefined -> still BUSY after 100 cycles.
REQ-042 rst pulsed in BUSY -> next cycle IDLE, o_fu_val=0, o_rdy=1; retire_cnt preset to 0xFFFFFFFF plus one legal completion -> 0.

Source files
------------

// File: rtl/cirno9_define.sv
// Shared definitions for the cirno9 execution dispatch block.
// Holds the dispatch FSM state encodings.
// CIRNO_EXU_TMO_EN (BUSY watchdog) is left undefined by default.
// Define it on the command line to build the watchdog in.
package cirno9_define;

  // Dispatch FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_WB   = 2'd2
  } exu_st_e;

`ifndef CIRNO_EXU_TMO_EN
  // Default build: watchdog disabled, BUSY waits on the FU indefinitely.
  localparam bit EXU_TMO_DEFAULT = 1'b0;
`else
  localparam bit EXU_TMO_DEFAULT = 1'b1;
`endif

endpackage

// File: rtl/exu_fu_mux.sv
// One-hot legality check plus AND-OR result select across NUM_FU channels.
// Purely combinational.
module exu_fu_mux #(
  parameter int NUM_FU = 4,
  parameter int XLEN   = 32
) (
  input  logic [NUM_FU-1:0]      sel_i,
  input  logic [NUM_FU-1:0]      rdy_i,
  input  logic [NUM_FU*XLEN-1:0] res_i,
  output logic                   legal_o,
  output logic                   hit_o,
  output logic [XLEN-1:0]        res_o
);

  logic [NUM_FU-1:0][XLEN-1:0] res_msk;

  // Each lane gates its own result with its select bit
  for (genvar k = 0; k < NUM_FU; k++) begin : g_lane
    assign res_msk[k] = res_i[k*XLEN +: XLEN] & {XLEN{sel_i[k]}};
  end

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero
  assign legal_o = (sel_i != '0) && ((sel_i & (sel_i - 1'b1)) == '0);

  // Only the selected FU's ready counts
  assign hit_o = |(sel_i & rdy_i);

  // OR-reduce the masked lanes
  always_comb begin
    res_o = '0;
    for (int k = 0; k < NUM_FU; k++) res_o = res_o | res_msk[k];
  end

endmodule

// File: rtl/exu_disp.sv
// Execution dispatch: issues one instruction at a time to a one-hot selected
// functional unit, waits for completion, then holds the result in WB until
// the writeback handshake. WB overlaps with the next accept (no bubble).
// Optional BUSY watchdog under CIRNO_EXU_TMO_EN.
module exu_disp
  import cirno9_define::*;
#(
  parameter int NUM_FU = 4,
  parameter int XLEN   = 32,
  parameter int TMO_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_val,
  output logic                   o_rdy,
  input  logic [NUM_FU-1:0]      i_sele,
  input  logic [XLEN-1:0]        i_pc,
  output logic [NUM_FU-1:0]      o_fu_val,
  input  logic [NUM_FU-1:0]      i_fu_rdy,
  input  logic [NUM_FU*XLEN-1:0] i_fu_res,
  output logic                   o_wb_val,
  input  logic                   i_wb_rdy,
  output logic [XLEN-1:0]        o_wb_res,
  output logic [XLEN-1:0]        o_wb_pc,
  output logic                   o_wb_ilg,
  output logic                   o_wb_tmo,
  output logic [31:0]            o_retire_cnt
);

  exu_st_e           state_q;
  logic [NUM_FU-1:0] sel_q, fu_val_q, mux_sel;
  logic [XLEN-1:0]   res_q, pc_q, mux_res;
  logic              ilg_q, mux_legal, mux_hit;
  logic              busy, acc, wb_hs, hit, tmo_fire;
  logic [31:0]       cnt_q;

  assign busy     = (state_q == ST_BUSY);
  assign o_wb_val = (state_q == ST_WB);
  assign o_rdy    = (state_q == ST_IDLE) || (o_wb_val && i_wb_rdy);
  assign acc      = i_val && o_rdy;
  assign wb_hs    = o_wb_val && i_wb_rdy;
  assign hit      = busy && mux_hit;

  // Accepts never happen in BUSY, so one mux serves both the legality check
  // of the incoming select and the result pick of the latched one.
  assign mux_sel = busy ? sel_q : i_sele;

  exu_fu_mux #(.NUM_FU(NUM_FU), .XLEN(XLEN)) u_mux (
    .sel_i   (mux_sel),
    .rdy_i   (i_fu_rdy),
    .res_i   (i_fu_res),
    .legal_o (mux_legal),
    .hit_o   (mux_hit),
    .res_o   (mux_res)
  );

`ifdef CIRNO_EXU_TMO_EN
  localparam logic [TMO_W-1:0] WDT_LAST = {TMO_W{1'b1}} - 1'b1;
  logic [TMO_W-1:0] wdt_q, wdt_d;
  logic             tmo_q;

  // Fires on the BUSY cycle where the count would reach all-ones; ready wins.
  assign tmo_fire = busy && !mux_hit && (wdt_q == WDT_LAST);
  assign wdt_d    = acc ? '0 : (busy ? wdt_q + 1'b1 : wdt_q);
  assign o_wb_tmo = tmo_q;

  // Watchdog counter and its sticky flag for the WB record
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      wdt_q <= wdt_d;
      if (acc)           tmo_q <= 1'b0;
      else if (tmo_fire) tmo_q <= 1'b1;
    end
  end
`else
  // Watchdog compiled out; TMO_W only sizes it when present.
  if (TMO_W >= 1) begin : g_no_wdt
    assign tmo_fire = 1'b0;
    assign o_wb_tmo = 1'b0;
  end
`endif

  // Dispatch FSM with registered FU request and WB record
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      fu_val_q <= '0;
      res_q    <= '0;
      pc_q     <= '0;
      ilg_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_BUSY: begin
          if (hit) begin
            res_q    <= mux_res;
            fu_val_q <= '0;
            state_q  <= ST_WB;
          end else if (tmo_fire) begin
            res_q    <= '0;
            fu_val_q <= '0;
            state_q  <= ST_WB;
          end
        end
        default: begin
          if (acc) begin
            sel_q <= i_sele;
            pc_q  <= i_pc;
            res_q <= '0;
            ilg_q <= !mux_legal;
            if (mux_legal) begin
              fu_val_q <= i_sele;
              state_q  <= ST_BUSY;
            end else begin
              state_q  <= ST_WB;
            end
          end else if (wb_hs) begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Retire counter: clean completions only, wraps naturally
  always_ff @(posedge clk) begin
    if (rst)                                cnt_q <= '0;
    else if (wb_hs && !ilg_q && !o_wb_tmo) cnt_q <= cnt_q + 32'd1;
  end

  assign o_fu_val     = fu_val_q;
  assign o_wb_res     = res_q;
  assign o_wb_pc      = pc_q;
  assign o_wb_ilg     = ilg_q;
  assign o_retire_cnt = cnt_q;

endmodule

// File: tb/tb_exu_disp.sv
// Scoreboard bench for exu_disp: stimulus pushes expected WB records, a
// negedge monitor pops and compares on every writeback handshake.
module tb_exu_disp;
  localparam int NF = 4;
  localparam int XL = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_val;
  logic          o_rdy;
  logic [NF-1:0] i_sele;
  logic [XL-1:0] i_pc;
  logic [NF-1:0] o_fu_val;
  logic [NF-1:0] i_fu_rdy;
  logic [NF*XL-1:0] i_fu_res;
  logic          o_wb_val;
  logic          i_wb_rdy;
  logic [XL-1:0] o_wb_res, o_wb_pc;
  logic          o_wb_ilg, o_wb_tmo;
  logic [31:0]   o_retire_cnt;

  typedef struct {
    logic [XL-1:0] res;
    logic [XL-1:0] pc;
    logic          ilg;
    logic          tmo;
  } wb_t;

  wb_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  exu_disp #(.NUM_FU(NF), .XLEN(XL), .TMO_W(4)) dut (
    .clk(clk), .rst(rst), .i_val(i_val), .o_rdy(o_rdy), .i_sele(i_sele),
    .i_pc(i_pc), .o_fu_val(o_fu_val), .i_fu_rdy(i_fu_rdy), .i_fu_res(i_fu_res),
    .o_wb_val(o_wb_val), .i_wb_rdy(i_wb_rdy), .o_wb_res(o_wb_res),
    .o_wb_pc(o_wb_pc), .o_wb_ilg(o_wb_ilg), .o_wb_tmo(o_wb_tmo),
    .o_retire_cnt(o_retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic wb_t mk(input logic [31:0] r, input logic [31:0] p,
                             input logic il, input logic tm);
    wb_t w;
    w.res = r; w.pc = p; w.ilg = il; w.tmo = tm;
    return w;
  endfunction

  // Monitor: compare each writeback handshake against the scoreboard head
  always @(negedge clk) begin
    if (!rst && o_wb_val && i_wb_rdy) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL wb_unexpected: got pc %h want none", o_wb_pc);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_res", o_wb_res, e.res);
        chk("wb_pc",  o_wb_pc,  e.pc);
        chk("wb_ilg", {31'd0, o_wb_ilg}, {31'd0, e.ilg});
        chk("wb_tmo", {31'd0, o_wb_tmo}, {31'd0, e.tmo});
      end
    end
  end

  initial begin
    int n;
    logic [NF-1:0] bad_sel [2];
    bad_sel[0] = 4'b0110;
    bad_sel[1] = 4'b0000;
    rst = 1'b1; i_val = 1'b0; i_sele = '0; i_pc = '0;
    i_fu_rdy = '0; i_fu_res = '0; i_wb_rdy = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_rdy",    {31'd0, o_rdy},    32'd1);
    chk("rst_wbval",  {31'd0, o_wb_val}, 32'd0);
    chk("rst_fuval",  {28'd0, o_fu_val}, 32'd0);
    chk("rst_res",    o_wb_res,          32'd0);
    chk("rst_flags",  {30'd0, o_wb_ilg, o_wb_tmo}, 32'd0);
    chk("rst_cnt",    o_retire_cnt,      32'd0);

    // Legal op on FU1, minimum latency; other FUs ready with junk
    tick();
    i_val = 1'b1; i_sele = 4'b0010; i_pc = 32'h100;
    exp_q.push_back(mk(32'h1234, 32'h100, 1'b0, 1'b0));
    tick();
    i_val = 1'b0;
    i_fu_rdy = 4'b1011;
    i_fu_res = {32'hDEAD0003, 32'hDEAD0002, 32'h00001234, 32'hBEEF0000};
    @(negedge clk);
    chk("busy_fuval", {28'd0, o_fu_val}, 32'h2);
    chk("busy_rdy",   {31'd0, o_rdy},    32'd0);
    chk("busy_wbval", {31'd0, o_wb_val}, 32'd0);
    tick();
    i_fu_rdy = '0;
    @(negedge clk);
    chk("lat_wbval", {31'd0, o_wb_val}, 32'd1);
    tick();
    @(negedge clk);
    chk("cnt_1",     o_retire_cnt,      32'd1);
    chk("idle_rdy",  {31'd0, o_rdy},    32'd1);

    // Illegal selects: multi-hot and zero go straight to WB, no FU request
    for (int i = 0; i < 2; i++) begin
      tick();
      i_val = 1'b1; i_sele = bad_sel[i]; i_pc = 32'h200 + 32'(i*4);
      exp_q.push_back(mk(32'h0, 32'h200 + 32'(i*4), 1'b1, 1'b0));
      tick();
      i_val = 1'b0;
      @(negedge clk);
      chk("ilg_fuval", {28'd0, o_fu_val}, 32'd0);
      chk("ilg_wbval", {31'd0, o_wb_val}, 32'd1);
      tick();
      @(negedge clk);
      chk("ilg_cnt", o_retire_cnt, 32'd1);
    end

    // WB stall for 5 cycles then back-to-back accept
    tick();
    i_wb_rdy = 1'b0;
    i_val = 1'b1; i_sele = 4'b0001; i_pc = 32'h300;
    exp_q.push_back(mk(32'h55AA, 32'h300, 1'b0, 1'b0));
    tick();
    i_val = 1'b0; i_fu_rdy = 4'b0001;
    i_fu_res = {32'h0, 32'h0, 32'h0, 32'h000055AA};
    tick();
    i_fu_rdy = '0; i_fu_res = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_wbval", {31'd0, o_wb_val}, 32'd1);
      chk("stall_rdy",   {31'd0, o_rdy},    32'd0);
      chk("stall_res",   o_wb_res,          32'h55AA);
      chk("stall_pc",    o_wb_pc,           32'h300);
      tick();
    end
    i_wb_rdy = 1'b1;
    i_val = 1'b1; i_sele = 4'b1000; i_pc = 32'h400;
    @(negedge clk);
    chk("b2b_rdy", {31'd0, o_rdy}, 32'd1);
    exp_q.push_back(mk(32'h7777, 32'h400, 1'b0, 1'b0));
    tick();
    i_val = 1'b0;
    @(negedge clk);
    chk("b2b_fuval", {28'd0, o_fu_val}, 32'h8);
    chk("b2b_wbval", {31'd0, o_wb_val}, 32'd0);
    chk("b2b_cnt",   o_retire_cnt,      32'd2);
    i_fu_rdy = 4'b1000; i_fu_res = {32'h00007777, 32'h0, 32'h0, 32'h0};
    tick();
    i_fu_rdy = '0;
    tick();
    @(negedge clk);
    chk("cnt_3", o_retire_cnt, 32'd3);

    // FU never ready on FU2
    tick();
    i_val = 1'b1; i_sele = 4'b0100; i_pc = 32'h500;
`ifdef CIRNO_EXU_TMO_EN
    exp_q.push_back(mk(32'h0, 32'h500, 1'b0, 1'b1));
`endif
    tick();
    i_val = 1'b0;
    n = 0;
`ifdef CIRNO_EXU_TMO_EN
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_wb_val) break;
      n++;
      tick();
    end
    chk("tmo_busy_cycles", n, 32'd15);
    chk("tmo_fuval", {28'd0, o_fu_val}, 32'd0);
    tick();
    @(negedge clk);
    chk("tmo_cnt", o_retire_cnt, 32'd3);
    tick();
    i_val = 1'b1; i_sele = 4'b0001; i_pc = 32'h600;
    tick();
    i_val = 1'b0;
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_wb_val || o_fu_val != 4'b0100) n++;
      tick();
    end
    chk("notmo_still_busy", n, 32'd0);
    chk("notmo_tmo", {31'd0, o_wb_tmo}, 32'd0);
`endif

    // Reset in BUSY abandons the op
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstb_fuval", {28'd0, o_fu_val}, 32'd0);
    chk("rstb_rdy",   {31'd0, o_rdy},    32'd1);
    chk("rstb_wbval", {31'd0, o_wb_val}, 32'd0);
    chk("rstb_cnt",   o_retire_cnt,      32'd0);

    // Retire counter wrap
    dut.cnt_q = 32'hFFFFFFFF;
    tick();
    i_val = 1'b1; i_sele = 4'b0010; i_pc = 32'h700;
    exp_q.push_back(mk(32'h0BAD, 32'h700, 1'b0, 1'b0));
    tick();
    i_val = 1'b0; i_fu_rdy = 4'b0010;
    i_fu_res = {32'h0, 32'h0, 32'h00000BAD, 32'h0};
    tick();
    i_fu_rdy = '0;
    tick();
    @(negedge clk);
    chk("wrap_cnt", o_retire_cnt, 32'd0);

    tick(); tick();
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
